// File: rtl/sfpp_stream_mux_pkg.sv
// Shared constants and types for the SFP+ stream multiplexer: address-map
// entry, register offsets, ID code and the arbitration FSM state type.
package sfpp_stream_mux_pkg;

  // Address-map entry for this block on the system Wishbone bus.
  localparam int          SFPP_MUX_IDX  = 5;
  localparam logic [31:0] SFPP_MUX_BASE = 32'h0000_0500;
  localparam logic [31:0] SFPP_MUX_SIZE = 32'h0000_0100;

  // Register word offsets inside the block.
  localparam logic [7:0] SFPP_MUX_ID   = 8'h00;
  localparam logic [7:0] SFPP_MUX_EN   = 8'h01;
  localparam logic [7:0] SFPP_MUX_FCNT = 8'h10;
  localparam logic [7:0] SFPP_MUX_DCNT = 8'h20;

  // "SF" identification code returned in the upper half of the ID register.
  localparam logic [15:0] SFPP_MUX_ID_CODE = 16'h5346;

  // Frame arbitration states: IDLE picks the next port, PASS forwards one frame.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } mux_state_e;

  // Port-index width with a floor of one bit so single-port builds stay legal.
  function automatic int port_id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/sfpp_stream_mux_if.sv
// Bundle of the per-port AXI4-Stream inputs, the merged AXI4-Stream output and
// the Wishbone register port. The mux itself uses the slave modport (it is the
// Wishbone slave); the upstream/bus-master side uses the master modport.
interface sfpp_stream_mux_if #(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 128,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PORT_ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);

  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tlast;

  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic                            m_axis_tlast;
  logic [PORT_ID_WIDTH-1:0]        m_axis_tid;

  logic [7:0]                      wb_adr;
  logic [31:0]                     wb_dat_i;
  logic [31:0]                     wb_dat_o;
  logic                            wb_we;
  logic                            wb_stb;
  logic                            wb_cyc;
  logic                            wb_ack;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
    input  m_axis_tready,
    input  wb_adr, wb_dat_i, wb_we, wb_stb, wb_cyc,
    output wb_dat_o, wb_ack
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
    output m_axis_tready,
    output wb_adr, wb_dat_i, wb_we, wb_stb, wb_cyc,
    input  wb_dat_o, wb_ack
  );

endinterface

// File: rtl/sfpp_stream_mux_rr_arbiter.sv
// Combinational round-robin search: starting just after last_grant_i, return
// the first requesting index. Kept generic for reuse on multi-lane designs.
module sfpp_stream_mux_rr_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int PORT_ID_WIDTH = 1
) (
  input  logic [NUM_PORTS-1:0]     req_i,
  input  logic [PORT_ID_WIDTH-1:0] last_grant_i,
  output logic [PORT_ID_WIDTH-1:0] grant_o,
  output logic                     valid_o
);

  int idx_s;

  // Walk the ring last_grant+1 .. last_grant+NUM_PORTS; first hit wins.
  always_comb begin
    grant_o = {PORT_ID_WIDTH{1'b0}};
    valid_o = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx_s = (int'(last_grant_i) + i) % NUM_PORTS;
      if (!valid_o && req_i[idx_s]) begin
        valid_o = 1'b1;
        grant_o = PORT_ID_WIDTH'(idx_s);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/sfpp_stream_mux.sv
// Frame-aware N-port AXI4-Stream multiplexer with per-frame round-robin
// arbitration, runtime port enables and per-port frame/drop counters on a
// Wishbone register port. Disabled ports are drained so their FIFOs never
// back up into the SFP+ receive path.
module sfpp_stream_mux
  import sfpp_stream_mux_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 128,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PORT_ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input logic               clk,
  input logic               rst,
  sfpp_stream_mux_if.slave  bus
);

  // Arbitration state
  mux_state_e               state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
  logic [PORT_ID_WIDTH-1:0] last_grant_q, last_grant_d;

  // Output stage
  logic                     m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0]    m_keep_q, m_keep_d;
  logic                     m_last_q, m_last_d;
  logic [PORT_ID_WIDTH-1:0] m_tid_q, m_tid_d;

  // Control/status registers
  logic [NUM_PORTS-1:0]     en_q, en_d;
  logic [31:0]              frame_cnt_q [NUM_PORTS];
  logic [31:0]              frame_cnt_d [NUM_PORTS];
  logic [31:0]              drop_cnt_q  [NUM_PORTS];
  logic [31:0]              drop_cnt_d  [NUM_PORTS];
  logic                     wb_ack_q, wb_ack_d;
  logic [31:0]              wb_dat_q, wb_dat_d;

  // Combinational helpers
  logic [NUM_PORTS-1:0]     req_s;
  logic [NUM_PORTS-1:0]     ready_s;
  logic [NUM_PORTS-1:0]     drain_s;
  logic [NUM_PORTS-1:0]     fcnt_inc_s, dcnt_inc_s;
  logic [NUM_PORTS-1:0]     fcnt_clr_s, dcnt_clr_s;
  logic                     arb_valid_s;
  logic [PORT_ID_WIDTH-1:0] arb_grant_s;
  logic                     out_free_s;
  logic                     sel_valid_s, sel_last_s;
  logic [DATA_WIDTH-1:0]    sel_data_s;
  logic [KEEP_WIDTH-1:0]    sel_keep_s;
  logic                     accept_s;
  logic                     wb_req_s, wb_wr_s;
  logic [31:0]              fcnt_sel_s, dcnt_sel_s, rd_data_s;

  assign req_s      = bus.s_axis_tvalid & en_q;
  assign out_free_s = !m_valid_q || bus.m_axis_tready;
  assign accept_s   = sel_valid_s && out_free_s;
  assign wb_req_s   = bus.wb_cyc && bus.wb_stb && !wb_ack_q;
  assign wb_wr_s    = wb_req_s && bus.wb_we;

  sfpp_stream_mux_rr_arbiter #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_rr_arbiter (
    .req_i        (req_s),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant_s),
    .valid_o      (arb_valid_s)
  );

  // Per-port ready/drain, selected-beat mux and counter event decode.
  always_comb begin
    ready_s     = {NUM_PORTS{1'b0}};
    drain_s     = {NUM_PORTS{1'b0}};
    fcnt_inc_s  = {NUM_PORTS{1'b0}};
    dcnt_inc_s  = {NUM_PORTS{1'b0}};
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DATA_WIDTH{1'b0}};
    sel_keep_s  = {KEEP_WIDTH{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((state_q == ST_PASS) && (grant_q == PORT_ID_WIDTH'(p))) begin
        ready_s[p]  = out_free_s;
        sel_valid_s = bus.s_axis_tvalid[p];
        sel_last_s  = bus.s_axis_tlast[p];
        sel_data_s  = bus.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_keep_s  = bus.s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
      end else if (!en_q[p]) begin
        ready_s[p] = 1'b1;
        drain_s[p] = 1'b1;
      end else begin
        ready_s[p] = 1'b0;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      fcnt_inc_s[p] = accept_s && sel_last_s && (grant_q == PORT_ID_WIDTH'(p));
      dcnt_inc_s[p] = drain_s[p] && bus.s_axis_tvalid[p] && bus.s_axis_tlast[p];
    end
  end

  // Next state: pick a port in IDLE, forward until the granted tlast in PASS.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_d = arb_grant_s;
          state_d = ST_PASS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (accept_s && sel_last_s) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= {PORT_ID_WIDTH{1'b0}};
      last_grant_q <= PORT_ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output stage: load on accept, hold while stalled, clear valid when drained.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_tid_d   = m_tid_q;
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data_s;
      m_keep_d  = sel_keep_s;
      m_last_d  = sel_last_s;
      m_tid_d   = grant_q;
    end else if (bus.m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Output stage registers; reset drops any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_WIDTH{1'b0}};
      m_keep_q  <= {KEEP_WIDTH{1'b0}};
      m_last_q  <= 1'b0;
      m_tid_q   <= {PORT_ID_WIDTH{1'b0}};
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_tid_q   <= m_tid_d;
    end
  end

  // Counter next values; a register write clears and beats a same-cycle increment.
  always_comb begin
    fcnt_clr_s = {NUM_PORTS{1'b0}};
    dcnt_clr_s = {NUM_PORTS{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      fcnt_clr_s[p] = wb_wr_s && (bus.wb_adr == (SFPP_MUX_FCNT + 8'(p)));
      dcnt_clr_s[p] = wb_wr_s && (bus.wb_adr == (SFPP_MUX_DCNT + 8'(p)));
      if (fcnt_clr_s[p]) begin
        frame_cnt_d[p] = 32'd0;
      end else if (fcnt_inc_s[p]) begin
        frame_cnt_d[p] = frame_cnt_q[p] + 32'd1;
      end else begin
        frame_cnt_d[p] = frame_cnt_q[p];
      end
      if (dcnt_clr_s[p]) begin
        drop_cnt_d[p] = 32'd0;
      end else if (dcnt_inc_s[p]) begin
        drop_cnt_d[p] = drop_cnt_q[p] + 32'd1;
      end else begin
        drop_cnt_d[p] = drop_cnt_q[p];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        frame_cnt_q[p] <= 32'd0;
        drop_cnt_q[p]  <= 32'd0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        frame_cnt_q[p] <= frame_cnt_d[p];
        drop_cnt_q[p]  <= drop_cnt_d[p];
      end
    end
  end

  // Register read mux plus enable/ack/read-data next values.
  always_comb begin
    fcnt_sel_s = 32'd0;
    dcnt_sel_s = 32'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      fcnt_sel_s = fcnt_sel_s | ((bus.wb_adr[3:0] == 4'(p)) ? frame_cnt_q[p] : 32'd0);
      dcnt_sel_s = dcnt_sel_s | ((bus.wb_adr[3:0] == 4'(p)) ? drop_cnt_q[p] : 32'd0);
    end
    case (bus.wb_adr[7:4])
      4'h0: begin
        if (bus.wb_adr == SFPP_MUX_ID) begin
          rd_data_s = {SFPP_MUX_ID_CODE, 8'd0, 8'(NUM_PORTS)};
        end else if (bus.wb_adr == SFPP_MUX_EN) begin
          rd_data_s = {{(32-NUM_PORTS){1'b0}}, en_q};
        end else begin
          rd_data_s = 32'd0;
        end
      end
      4'h1:    rd_data_s = fcnt_sel_s;
      4'h2:    rd_data_s = dcnt_sel_s;
      default: rd_data_s = 32'd0;
    endcase
    if (wb_wr_s && (bus.wb_adr == SFPP_MUX_EN)) begin
      en_d = bus.wb_dat_i[NUM_PORTS-1:0];
    end else begin
      en_d = en_q;
    end
    wb_ack_d = wb_req_s;
    if (wb_req_s) begin
      wb_dat_d = rd_data_s;
    end else begin
      wb_dat_d = wb_dat_q;
    end
  end

  // Wishbone-side registers: enable mask, ack pulse and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= {NUM_PORTS{1'b1}};
      wb_ack_q <= 1'b0;
      wb_dat_q <= 32'd0;
    end else begin
      en_q     <= en_d;
      wb_ack_q <= wb_ack_d;
      wb_dat_q <= wb_dat_d;
    end
  end

  assign bus.s_axis_tready = ready_s;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tkeep  = m_keep_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign bus.m_axis_tid    = m_tid_q;
  assign bus.wb_ack        = wb_ack_q;
  assign bus.wb_dat_o      = wb_dat_q;

endmodule

// File: tb/tb_sfpp_stream_mux.sv
// Self-checking bench for sfpp_stream_mux: per-port frame queues feed the DUT,
// a scoreboard holds the beats each port is expected to deliver, and counter
// registers are compared against frame/drop tallies kept by the bench.
module tb_sfpp_stream_mux;

  localparam int NP = 2;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int PW = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sfpp_stream_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PORT_ID_WIDTH(PW)) bus ();

  sfpp_stream_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PORT_ID_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  beat_t in_q0[$], in_q1[$], exp_q0[$], exp_q1[$];
  int    exp_fcnt[NP];
  int    exp_dcnt[NP];
  int    obs_tid[$];
  int    obs_cyc[$];
  bit    ready_pat[$];
  int    ready_mode = 0;
  int    cyc = 0;
  int    acc0_cnt = 0;
  int    first_acc0 = 0;
  bit    fire0 = 1'b0, fire1 = 1'b0;
  bit    in_frame = 1'b0;
  int    cur_tid = 0;
  bit    stalled_prev = 1'b0;
  beat_t snap;
  int    snap_tid = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard one delivered output beat against the source port's queue.
  task automatic score_beat(input beat_t ob, input int t);
    beat_t e;
    int avail;
    obs_tid.push_back(t);
    obs_cyc.push_back(cyc);
    if (in_frame) check_eq("contig_tid", t, cur_tid);
    avail = (t == 0) ? exp_q0.size() : ((t == 1) ? exp_q1.size() : 0);
    check_eq("out_expected", avail > 0, 1'b1);
    if (avail > 0) begin
      if (t == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check_eq("out_data", ob.data, e.data);
      check_eq("out_keep", ob.keep, e.keep);
      check_eq("out_last", ob.last, e.last);
    end
    in_frame = !ob.last;
    cur_tid  = t;
  endtask

  // Bus-functional driver/monitor: inputs change on the falling edge.
  initial begin
    beat_t b, ob;
    logic [2*DW-1:0] td;
    logic [2*KW-1:0] tk;
    forever begin
      @(negedge clk);
      cyc++;
      if (fire0 && in_q0.size() > 0) b = in_q0.pop_front();
      if (fire1 && in_q1.size() > 0) b = in_q1.pop_front();
      case (ready_mode)
        0: bus.m_axis_tready = 1'b1;
        1: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        2: bus.m_axis_tready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
        default: bus.m_axis_tready = 1'b1;
      endcase
      td = '0; tk = '0;
      bus.s_axis_tvalid = 2'b00;
      bus.s_axis_tlast  = 2'b00;
      if (in_q0.size() > 0) begin
        td[DW-1:0] = in_q0[0].data; tk[KW-1:0] = in_q0[0].keep;
        bus.s_axis_tvalid[0] = 1'b1; bus.s_axis_tlast[0] = in_q0[0].last;
      end
      if (in_q1.size() > 0) begin
        td[2*DW-1:DW] = in_q1[0].data; tk[2*KW-1:KW] = in_q1[0].keep;
        bus.s_axis_tvalid[1] = 1'b1; bus.s_axis_tlast[1] = in_q1[0].last;
      end
      bus.s_axis_tdata = td;
      bus.s_axis_tkeep = tk;
      #1;
      if (rst) begin
        fire0 = 1'b0; fire1 = 1'b0; stalled_prev = 1'b0;
      end else begin
        fire0 = bus.s_axis_tvalid[0] && bus.s_axis_tready[0];
        fire1 = bus.s_axis_tvalid[1] && bus.s_axis_tready[1];
        if (fire0) begin
          if (acc0_cnt == 0) first_acc0 = cyc;
          acc0_cnt++;
        end
        if (stalled_prev) check_eq("stall_valid", bus.m_axis_tvalid, 1'b1);
        if (bus.m_axis_tvalid) begin
          ob = '{data: bus.m_axis_tdata, keep: bus.m_axis_tkeep, last: bus.m_axis_tlast};
          if (stalled_prev) begin
            check_eq("stall_data", ob.data, snap.data);
            check_eq("stall_ctl", {ob.keep, ob.last}, {snap.keep, snap.last});
            check_eq("stall_tid", int'(bus.m_axis_tid), snap_tid);
          end
          if (bus.m_axis_tready) begin
            score_beat(ob, int'(bus.m_axis_tid));
            stalled_prev = 1'b0;
          end else begin
            stalled_prev = 1'b1;
            snap = ob;
            snap_tid = int'(bus.m_axis_tid);
          end
        end else begin
          stalled_prev = 1'b0;
        end
      end
    end
  end

  // Queue one frame on a port; fwd says whether it should reach the output.
  task automatic push_frame(input int port, input int len, input bit fwd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == len - 1);
      b.keep = b.last ? (16'hFFFF >> $urandom_range(0, 15)) : 16'hFFFF;
      if (port == 0) in_q0.push_back(b); else in_q1.push_back(b);
      if (fwd) begin
        if (port == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
      end
    end
    if (fwd) exp_fcnt[port]++; else exp_dcnt[port]++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (in_q0.size() + in_q1.size() + exp_q0.size() + exp_q1.size() == 0 && !bus.m_axis_tvalid) break;
    end
    check_eq(tag, in_q0.size() + in_q1.size() + exp_q0.size() + exp_q1.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wb_xfer(input logic [7:0] a, input bit we, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    bus.wb_adr = a; bus.wb_we = we; bus.wb_dat_i = wd;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.wb_ack && n < 20);
    check_eq("wb_ack", bus.wb_ack, 1'b1);
    rd = bus.wb_dat_o;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, dummy);
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 1'b0, 32'd0, rd);
    check_eq(tag, rd, exp);
  endtask

  task automatic check_all_regs_reset();
    check_reg("reg_id", 8'h00, 32'h5346_0002);
    check_reg("reg_en", 8'h01, 32'h0000_0003);
    check_reg("reg_fcnt0", 8'h10, 32'd0);
    check_reg("reg_fcnt1", 8'h11, 32'd0);
    check_reg("reg_dcnt0", 8'h20, 32'd0);
    check_reg("reg_dcnt1", 8'h21, 32'd0);
    check_reg("reg_unmapped", 8'h30, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 0, 0, 1, 1, 1};
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = '0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = '0;
    bus.wb_adr = 8'h00; bus.wb_dat_i = 32'd0; bus.wb_we = 1'b0; bus.wb_stb = 1'b0; bus.wb_cyc = 1'b0;
    for (int p = 0; p < NP; p++) begin exp_fcnt[p] = 0; exp_dcnt[p] = 0; end
    #23;
    check_eq("rst_m_valid", bus.m_axis_tvalid, 1'b0);
    check_eq("rst_s_ready", bus.s_axis_tready, 2'b00);
    check_eq("rst_m_data", bus.m_axis_tdata, 128'd0);
    check_eq("rst_m_ctl", {bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tid}, 18'd0);
    check_eq("rst_wb", {bus.wb_ack, bus.wb_dat_o}, 33'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    check_all_regs_reset();

    // Ack is a single pulse even while the request is held.
    @(posedge clk); #1;
    bus.wb_adr = 8'h00; bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    @(posedge clk); #1;
    check_eq("ack_pulse_hi", bus.wb_ack, 1'b1);
    @(posedge clk); #1;
    check_eq("ack_pulse_lo", bus.wb_ack, 1'b0);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    repeat (2) @(posedge clk);

    // Single 4-beat frame on port 0.
    obs_tid.delete(); obs_cyc.delete(); acc0_cnt = 0;
    push_frame(0, 4, 1'b1);
    wait_drain("t1_drain", 200);
    check_eq("t1_beats", obs_tid.size(), 4);
    if (obs_cyc.size() > 0) check_eq("t1_latency", obs_cyc[0] - first_acc0, 1);
    check_reg("t1_fcnt0", 8'h10, exp_fcnt[0]);

    // Make port 1 the last grant, clear counts, then both ports at once.
    push_frame(1, 1, 1'b1);
    wait_drain("t2_pre_drain", 200);
    wb_write(8'h10, 32'hFFFF_FFFF);
    wb_write(8'h11, 32'h0);
    exp_fcnt[0] = 0; exp_fcnt[1] = 0;
    check_reg("t2_fcnt0_clr", 8'h10, 32'd0);
    obs_tid.delete(); obs_cyc.delete();
    push_frame(0, 3, 1'b1);
    push_frame(1, 3, 1'b1);
    wait_drain("t2_drain", 200);
    check_eq("t2_beats", obs_tid.size(), 6);
    if (obs_tid.size() == 6) begin
      for (int i = 0; i < 6; i++) check_eq("t2_rr_tid", obs_tid[i], exp_seq[i]);
      check_eq("t2_back_to_back", obs_cyc[1] - obs_cyc[0], 1);
      check_eq("t2_frame_gap", obs_cyc[3] - obs_cyc[2], 2);
    end
    check_reg("t2_fcnt0", 8'h10, exp_fcnt[0]);
    check_reg("t2_fcnt1", 8'h11, exp_fcnt[1]);

    // Output stalls mid-frame.
    ready_mode = 2;
    ready_pat.delete();
    ready_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    push_frame(0, 6, 1'b1);
    wait_drain("t3_drain", 200);
    ready_mode = 0;

    // Port 1 disabled: its frames are drained and counted as drops.
    wb_write(8'h01, 32'h1);
    check_reg("t4_en", 8'h01, 32'h1);
    @(posedge clk); #1;
    check_eq("t4_drain_ready", bus.s_axis_tready[1], 1'b1);
    push_frame(1, 2, 1'b0);
    push_frame(1, 2, 1'b0);
    wait_drain("t4_drain", 200);
    check_reg("t4_dcnt1", 8'h21, exp_dcnt[1]);
    wb_write(8'h01, 32'h3);

    // Disable port 0 in the middle of its frame.
    acc0_cnt = 0;
    push_frame(0, 5, 1'b1);
    for (int i = 0; i < 50 && acc0_cnt < 1; i++) @(posedge clk);
    check_eq("t5_started", acc0_cnt > 0, 1'b1);
    wb_write(8'h01, 32'h2);
    push_frame(0, 5, 1'b0);
    wait_drain("t5_drain", 200);
    check_reg("t5_dcnt0", 8'h20, exp_dcnt[0]);
    check_reg("t5_fcnt0", 8'h10, exp_fcnt[0]);
    wb_write(8'h01, 32'h3);

    // Randomized traffic with random output backpressure.
    ready_mode = 1;
    for (int k = 0; k < 24; k++) begin
      push_frame($urandom_range(0, 1), $urandom_range(1, 6), 1'b1);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain("rand_drain", 3000);
    ready_mode = 0;
    check_reg("rand_fcnt0", 8'h10, exp_fcnt[0]);
    check_reg("rand_fcnt1", 8'h11, exp_fcnt[1]);

    // Asynchronous reset in the middle of a frame.
    acc0_cnt = 0;
    push_frame(0, 12, 1'b1);
    for (int i = 0; i < 50 && acc0_cnt < 3; i++) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_m_valid", bus.m_axis_tvalid, 1'b0);
    check_eq("arst_s_ready", bus.s_axis_tready, 2'b00);
    in_q0.delete(); in_q1.delete(); exp_q0.delete(); exp_q1.delete();
    fire0 = 1'b0; fire1 = 1'b0; in_frame = 1'b0; stalled_prev = 1'b0;
    #20;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    check_all_regs_reset();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/sfpp_stream_mux.md
Name: sfpp_stream_mux

Overview:
Frame-aware N-port AXI4-Stream multiplexer. It merges the per-port Ethernet RX streams of a multi-SFP+ design into the single `data_stream` that feeds the FCS checker and `si_data_channel`. It sits after each port's async FIFO/width adapter, so all inputs are already in the sys_clk domain. Arbitration is round-robin per whole frame. Ports can be enabled or disabled at runtime over Wishbone, and the block keeps per-port frame and drop counters.

Parameters:
- NUM_PORTS, 2: number of input streams, 1..8.
- DATA_WIDTH, 128: tdata width per port, in bits.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- PORT_ID_WIDTH, $clog2(NUM_PORTS) with a minimum of 1: width of the m_axis_tid field.

Ports:
- clk  in  1  sys_clk
- rst  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port keep
- s_axis_tlast  in  NUM_PORTS  per-port last
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  merged ready
- m_axis_tdata  out  DATA_WIDTH  merged data
- m_axis_tkeep  out  KEEP_WIDTH  merged keep
- m_axis_tlast  out  1  merged last
- m_axis_tid  out  PORT_ID_WIDTH  index of the source port
- wb_adr  in  8  Wishbone word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_we, wb_stb, wb_cyc  in  1 each  Wishbone control
- wb_ack  out  1  Wishbone acknowledge

Behaviour:
- Reset is asynchronous and active-high on `rst`; the block has one clock, `clk`.
- Reset values:
  - all m_axis_* outputs are 0; s_axis_tready is all 0.
  - wb_ack = 0, wb_dat_o = 0.
  - enable mask = all ones; all counters = 0.
  - state = IDLE; last_grant = NUM_PORTS-1.
- FSM state IDLE:
  - Search ports in order last_grant+1, last_grant+2, … (modulo NUM_PORTS).
  - The first port with tvalid=1 and enable=1 becomes `grant`; go to PASS on the next cycle.
  - With no candidate, remain in IDLE.
- FSM state PASS:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready); all other ready bits are 0, except for draining ports (see below).
  - An accepted input beat is registered into the output stage, with m_axis_tid = grant.
  - When an accepted beat has tlast=1: frame_count[grant] increments, last_grant <= grant, and the state returns to IDLE.
- Latency and throughput:
  - Latency is one cycle from input acceptance to m_axis_tvalid.
  - There is one idle arbitration cycle between frames.
  - Throughput within a frame is one beat per cycle.
- Output register:
  - It holds its value while m_axis_tvalid && !m_axis_tready (AXI-stable).
  - It clears m_axis_tvalid when it is drained and there is no new beat.
- Disabled port:
  - A disabled port is never granted.
  - When it is not the current grant, s_axis_tready for that port is held at 1, so its data is consumed and discarded.
  - Each discarded tlast beat increments drop_count[p].
- Disable mid-frame: the granted frame completes normally. Draining of that port starts after its tlast.
- Simultaneous arrival: round-robin order decides. A port that was just granted has the lowest priority in the next IDLE cycle.
- Counters: 32-bit, wrap at 2^32. Writing any value to a counter address clears it; if that write coincides with an increment, the clear wins.
- Wishbone register map:
  - 0x00 (read only): {16'h5346 "SF", 8'd0, NUM_PORTS[7:0]}.
  - 0x01 (read/write): enable mask; bits [NUM_PORTS-1:0] are used, upper bits read 0.
  - 0x10+p: frame_count[p].
  - 0x20+p: drop_count[p].
  - Any other address reads 0; writes to it are ignored.
- Wishbone acknowledge:
  - wb_ack is a one-cycle pulse one cycle after cyc && stb.
  - wb_ack is forced to 0 in the cycle following an ack, so one request produces one ack.
- Reset mid-frame: the output is dropped immediately, with no partial-frame recovery. The downstream FCS checker discards the truncated frame.

Decomposition:
- Shared package additions (pkg_base_address):
  - a `sfpp_mux` instance index with its base address and memory space;
  - register offset constants SFPP_MUX_ID=8'h00, SFPP_MUX_EN=8'h01, SFPP_MUX_FCNT=8'h10, SFPP_MUX_DCNT=8'h20;
  - ID constant 16'h5346.
- One sub-module: `rr_arbiter`, a combinational round-robin search taking the request vector and last_grant and returning grant index plus valid. It is reusable for the later 40G multi-lane work.

Test Plan:
- Port 0 alone sends a 4-beat frame with m_tready=1 → m_axis shows 4 beats with tid=0, first beat one cycle after acceptance; tlast on beat 4; reg 0x10 reads 1.
- Ports 0 and 1 both valid with 3-beat frames, last_grant=1 → port 0 frame first, one idle cycle, then port 1; tid sequence 0,0,0,1,1,1; both frame counts = 1.
- m_tready toggles 1,0,0,1 during a frame → tdata/tkeep/tlast/tid remain stable while stalled; no beats lost or duplicated.
- Write 0x01 = 0x1, then port 1 sends two 2-beat frames → port 1 tready held at 1; no output with tid=1; reg 0x21 reads 2.
- Clear the port 0 enable during the 2nd beat of a 5-beat port 0 frame → all 5 beats are forwarded; the next port 0 frame is dropped; reg 0x20 reads 1.
- Assert rst asynchronously mid-frame → m_axis_tvalid=0 and s_axis_tready=0 in the same cycle; after release, reg 0x01 reads 0x3 and all counters read 0.
